vga_frame_reader: RTL
=====================

// Module: vga_frame_reader
// PURPOSE
//  Reads the filtered 640x480 4-bit frame buffer after the edge filter has finished writing it.
//  Generates standard 640x480@60 VGA timing and issues sequential BRAM read addresses.
//  Drives the returned pixels to the display with hsync/vsync/blank aligned to pixel data.
//  Sits between the filtered-frame BRAM read port and the VGA DAC pins.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line; H_FP 16; H_SYNC 96; H_BP 48 (line total 800)
//  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33 (frame total 525)
//  ADDR_W   19  BRAM address width
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   async active-low reset
//  pix_en       in   1   pixel-clock enable, one-clk pulse (25 MHz tick)
//  frame_ready  in   1   level; high = buffer holds a complete filtered frame
//  read_pixel   in   4   BRAM read data; valid RD_LAT=1 clk after read_address
//  read_address out  19  BRAM read address
//  vga_pixel    out  4   grey level to DAC; 0 outside active area
//  hsync        out  1   active-low horizontal sync
//  vsync        out  1   active-low vertical sync
//  blank_n      out  1   high when vga_pixel is an active-area pixel
//  frame_start  out  1   one-clk pulse when a SCAN frame begins
// BEHAVIOUR
//  Reset (async): h_cnt=0, v_cnt=0, state=WAIT, read_address=0, vga_pixel=0,
//   hsync=1, vsync=1, blank_n=0, frame_start=0.
//  All counters and pipeline stages advance only on clk edges with pix_en=1. pix_en=0 holds all state.
//  Counters: h_cnt 0..799, wraps to 0 and increments v_cnt; v_cnt 0..524, wraps to 0.
//  Timing runs freely in both states; only pixel data is state-dependent.
//  FSM: WAIT, SCAN. Decision only at frame boundary (pix_en with h_cnt=799, v_cnt=524):
//   frame_ready=1 -> SCAN for the next full frame, with frame_start pulse on that edge;
//   frame_ready=0 -> WAIT. frame_ready changes mid-frame are ignored until the next boundary.
//  Address: held 0 outside active area. Increments by 1 per active pixel in SCAN.
//   Equals v_cnt*640+h_cnt; computed incrementally, no multiplier.
//   Stays 0 in WAIT. Reloads 0 at every frame boundary; last active pixel = 307199.
//  Pipeline: 2 pix_en stages.
//   Stage0 registers read_address plus raw sync/active flags.
//   Stage1 captures read_pixel into vga_pixel and registers the delayed flags.
//   Sync/blank are therefore aligned with the data. Requires pix_en period >= 2 clk.
//  Sync decode (pre-delay): hsync=0 for h_cnt 656..751; vsync=0 for v_cnt 490..491.
//   Active area: h_cnt<640 && v_cnt<480.
//  vga_pixel = read_pixel when delayed active && SCAN-frame; otherwise 0.
//   blank_n = delayed active in both states.
//  Reset mid-frame: immediate return to reset values; next frame starts from h=0, v=0 in WAIT.
//  frame_ready is synchronous to clk; no CDC inside this block.
// TESTING
//  1 Reset, pix_en every 2nd clk, frame_ready=0: hsync low 96 px every 800.
//    vsync low 2 lines every 525. vga_pixel=0 always, read_address=0.
//  2 frame_ready=1 before boundary, BRAM model data=addr[3:0]: frame_start one pulse.
//    First active vga_pixel=0 two pix_en after h=0, v=0; pixel 17 of line 0 = 1.
//    read_address reaches 307199 then 0.
//  3 Drop frame_ready at v_cnt=200: SCAN continues to line 479.
//    Next frame is WAIT: all pixels 0, no frame_start.
//  4 Hold pix_en=0 for 10 clk mid-line: no counter, address or output change; resumes exactly.
//  5 Assert rst_n=0 at h=300, v=100 in SCAN: outputs go to reset values asynchronously.
//    After release, state=WAIT.
//  6 Check alignment: blank_n rises on the same pix_en as the first valid pixel.
//    hsync edges occur 656 and 752 px after line start, each delayed by 2 pix_en.

Source files
------------

// File: rtl/vga_frame_reader.sv
// Scans a filtered 4-bit frame buffer out as VGA video, with sync and blank aligned to the pixel data.
// Latency is 2 pix_en ticks from counter position to the pins. There is no backpressure: pix_en is the only throttle.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic              frame_ready,
    input  logic [3:0]        read_pixel,
    output logic [ADDR_W-1:0] read_address,
    output logic [3:0]        vga_pixel,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {WAIT, SCAN} state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0] read_address_q, read_address_d;
    logic              fetch0_q, fetch0_d;
    logic              act0_q, act0_d;
    logic              hs0_q, hs0_d;
    logic              vs0_q, vs0_d;
    logic [3:0]        vga_pixel_q, vga_pixel_d;
    logic              blank_n_q, blank_n_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              frame_start_q, frame_start_d;

    logic line_end, frame_end, active, fetch, hs_raw, vs_raw;

    always_comb begin
        line_end  = (h_cnt_q == H_LAST);
        frame_end = line_end && (v_cnt_q == V_LAST);
        active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        fetch     = active && (state_q == SCAN);
        hs_raw    = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        vs_raw    = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    end

    always_comb begin
        state_d        = state_q;
        h_cnt_d        = h_cnt_q;
        v_cnt_d        = v_cnt_q;
        addr_cnt_d     = addr_cnt_q;
        read_address_d = read_address_q;
        fetch0_d       = fetch0_q;
        act0_d         = act0_q;
        hs0_d          = hs0_q;
        vs0_d          = vs0_q;
        vga_pixel_d    = vga_pixel_q;
        blank_n_d      = blank_n_q;
        hsync_d        = hsync_q;
        vsync_d        = vsync_q;
        frame_start_d  = 1'b0;

        if (pix_en) begin
            h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
            if (line_end) begin
                v_cnt_d = frame_end ? '0 : v_cnt_q + 1'b1;
            end

            // Running address replaces v*H_ACTIVE+h; it only moves on fetched pixels.
            if (frame_end) begin
                addr_cnt_d = '0;
            end else if (fetch) begin
                addr_cnt_d = addr_cnt_q + 1'b1;
            end

            read_address_d = fetch ? addr_cnt_q : '0;
            fetch0_d       = fetch;
            act0_d         = active;
            hs0_d          = hs_raw;
            vs0_d          = vs_raw;

            vga_pixel_d = fetch0_q ? read_pixel : 4'd0;
            blank_n_d   = act0_q;
            hsync_d     = hs0_q;
            vsync_d     = vs0_q;

            if (frame_end) begin
                state_d       = frame_ready ? SCAN : WAIT;
                frame_start_d = frame_ready;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WAIT;
            h_cnt_q        <= '0;
            v_cnt_q        <= '0;
            addr_cnt_q     <= '0;
            read_address_q <= '0;
            fetch0_q       <= 1'b0;
            act0_q         <= 1'b0;
            hs0_q          <= 1'b1;
            vs0_q          <= 1'b1;
            vga_pixel_q    <= 4'd0;
            blank_n_q      <= 1'b0;
            hsync_q        <= 1'b1;
            vsync_q        <= 1'b1;
            frame_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            addr_cnt_q     <= addr_cnt_d;
            read_address_q <= read_address_d;
            fetch0_q       <= fetch0_d;
            act0_q         <= act0_d;
            hs0_q          <= hs0_d;
            vs0_q          <= vs0_d;
            vga_pixel_q    <= vga_pixel_d;
            blank_n_q      <= blank_n_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign read_address = read_address_q;
    assign vga_pixel    = vga_pixel_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign blank_n      = blank_n_q;
    assign frame_start  = frame_start_q;

endmodule
